// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - shared constants for the Maple bus receiver
package maple_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    localparam int BIT_BUSY      = 0;
    localparam int BIT_DONE      = 1;
    localparam int BIT_START_ERR = 2;
    localparam int BIT_PROTO_ERR = 3;
    localparam int BIT_OVERFLOW  = 4;
    localparam int BIT_TIMEOUT   = 5;

    localparam logic [3:0] START_FALLS = 4'd4;
    localparam logic [3:0] END_FALLS   = 4'd2;

endpackage

// File: rtl/maple_in_if.sv
// rtl/maple_in_if.sv - RX FIFO push interface between receiver and FIFO
interface maple_in_if;
    logic [7:0] fifo_data;
    logic       data_produce;
    logic       space_avail;

    modport master (output fifo_data, output data_produce, input space_avail);
    modport slave  (input fifo_data, input data_produce, output space_avail);
endinterface

// File: rtl/maple_edge_sync.sv
// rtl/maple_edge_sync.sv - two-flop synchronizer with fall/rise detect for one bus line
module maple_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // Idle bus is high, so reset to 1 to avoid a spurious fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign fall_o  = hist_q & ~sync2_q;
    assign rise_o  = ~hist_q & sync2_q;

endmodule

// File: rtl/maple_in.sv
// rtl/maple_in.sv - Maple bus receiver: start/data/end decode, byte push, status register
module maple_in
    import maple_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_ctrl,
    input  logic       we,
    inout  wire  [7:0] regdata_out,
    input  logic [7:0] regdata_in,
    input  logic       pin1,
    input  logic       pin5,
    input  logic       tx_active,
    input  logic       tick,
    maple_in_if.master fifo
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_TICKS - 1);

    logic lvl1, fall1, rise1;
    logic lvl5, fall5, rise5;

    maple_edge_sync u_sync1 (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (pin1),
        .level_o (lvl1),
        .fall_o  (fall1),
        .rise_o  (rise1)
    );

    maple_edge_sync u_sync5 (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (pin5),
        .level_o (lvl5),
        .fall_o  (fall5),
        .rise_o  (rise5)
    );

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] tmo_q, tmo_d;
    logic [5:1] flags_q, flags_d;
    logic       enable_q, enable_d;
    logic [7:0] fifo_data_q, fifo_data_d;
    logic       produce_q, produce_d;

    logic       listen;
    logic       f1, r1, f5, r5, any_edge;
    logic [5:1] flag_set;
    logic       shift_en, shift_bit;
    logic [7:0] status;

    assign listen   = enable_q & ~tx_active;
    assign f1       = fall1 & listen;
    assign r1       = rise1 & listen;
    assign f5       = fall5 & listen;
    assign r5       = rise5 & listen;
    assign any_edge = f1 | r1 | f5 | r5;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        enable_d    = enable_q;
        fifo_data_d = fifo_data_q;
        produce_d   = 1'b0;
        flag_set    = '0;
        shift_en    = 1'b0;
        shift_bit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (f1 && lvl5) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (f1 && f5) begin
                    flag_set[BIT_PROTO_ERR] = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (f5) cnt_d = cnt_q + 4'd1;
                    if (r1) begin
                        if (cnt_d == START_FALLS) begin
                            state_d  = ST_DATA;
                            bitcnt_d = '0;
                        end else begin
                            flag_set[BIT_START_ERR] = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (f1 && f5) begin
                    flag_set[BIT_PROTO_ERR] = 1'b1;
                    state_d = ST_IDLE;
                end else if (!bitcnt_q[0]) begin
                    // Even phase: pin1 clocks pin5; a pin5 fall on a byte boundary opens END.
                    if (f5) begin
                        if (bitcnt_q == 3'd0) begin
                            state_d = ST_END;
                            cnt_d   = '0;
                        end else begin
                            flag_set[BIT_PROTO_ERR] = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (f1) begin
                        shift_en  = 1'b1;
                        shift_bit = lvl5;
                    end
                end else begin
                    if (f1) begin
                        flag_set[BIT_PROTO_ERR] = 1'b1;
                        state_d = ST_IDLE;
                    end else if (f5) begin
                        shift_en  = 1'b1;
                        shift_bit = lvl1;
                    end
                end
            end
            default: begin
                if (f1 && f5) begin
                    flag_set[BIT_PROTO_ERR] = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (f1) cnt_d = cnt_q + 4'd1;
                    if (r5) begin
                        if (cnt_d == END_FALLS) flag_set[BIT_DONE] = 1'b1;
                        else                    flag_set[BIT_PROTO_ERR] = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (shift_en) begin
            shreg_d  = {shreg_q[6:0], shift_bit};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                if (fifo.space_avail) begin
                    fifo_data_d = shreg_d;
                    produce_d   = 1'b1;
                end else begin
                    flag_set[BIT_OVERFLOW] = 1'b1;
                end
            end
        end

        if (state_q == ST_IDLE || any_edge || !listen) begin
            tmo_d = '0;
        end else if (tick) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d   = '0;
                state_d = ST_IDLE;
                flag_set[BIT_TIMEOUT] = 1'b1;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end

        // Losing the bus (transmitter or disable) abandons the frame silently.
        if (!listen) state_d = ST_IDLE;

        if (cs_ctrl && we) begin
            enable_d = regdata_in[0];
            if (!regdata_in[0]) begin
                state_d   = ST_IDLE;
                produce_d = 1'b0;
                flag_set  = '0;
            end
        end

        flags_d = flags_q;
        if (cs_ctrl && we) flags_d = flags_q & ~regdata_in[5:1];
        flags_d = flags_d | flag_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            tmo_q       <= '0;
            flags_q     <= '0;
            enable_q    <= 1'b0;
            fifo_data_q <= '0;
            produce_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
            flags_q     <= flags_d;
            enable_q    <= enable_d;
            fifo_data_q <= fifo_data_d;
            produce_q   <= produce_d;
        end
    end

    assign status            = {2'b00, flags_q, state_q != ST_IDLE};
    assign regdata_out       = (cs_ctrl && !we) ? status : 8'bz;
    assign fifo.fifo_data    = fifo_data_q;
    assign fifo.data_produce = produce_q;

endmodule

// File: tb/tb_maple_in.sv
// tb/tb_maple_in.sv - randomized self-checking bench for maple_in
module tb_maple_in;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_ctrl = 1'b0;
    logic       we = 1'b0;
    logic [7:0] regdata_in = 8'h00;
    wire  [7:0] regdata_out;
    logic       pin1 = 1'b1;
    logic       pin5 = 1'b1;
    logic       tx_active = 1'b0;
    logic       tick = 1'b0;

    maple_in_if fifo_if ();

    maple_in #(.TIMEOUT_TICKS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs_ctrl     (cs_ctrl),
        .we          (we),
        .regdata_out (regdata_out),
        .regdata_in  (regdata_in),
        .pin1        (pin1),
        .pin5        (pin5),
        .tx_active   (tx_active),
        .tick        (tick),
        .fifo        (fifo_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_flags = 8'h00;
    int tcnt = 0;

    always @(negedge clk) begin
        tcnt = (tcnt == 9) ? 0 : tcnt + 1;
        tick = (tcnt == 0);
    end

    // Every push must match the oldest byte the bench expects.
    always @(negedge clk) begin
        if (!rst && fifo_if.data_produce) begin
            logic [7:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push actual=%02h expected=none", fifo_if.fifo_data);
            end else begin
                e = exp_q.pop_front();
                if (fifo_if.fifo_data !== e) begin
                    errors++;
                    $display("FAIL push_data actual=%02h expected=%02h", fifo_if.fifo_data, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p1, input logic p5);
        @(negedge clk);
        pin1 = p1;
        pin5 = p5;
        repeat (4 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] v);
        @(negedge clk);
        cs_ctrl = 1'b1; we = 1'b1; regdata_in = v;
        @(negedge clk);
        cs_ctrl = 1'b0; we = 1'b0;
        if (v[0] == 1'b0) model_flags = 8'h00;
        else model_flags = model_flags & ~(v & 8'h3e);
    endtask

    task automatic read_status(output logic [7:0] v);
        repeat (4) @(negedge clk);
        cs_ctrl = 1'b1; we = 1'b0;
        #1 v = regdata_out;
        cs_ctrl = 1'b0;
    endtask

    task automatic send_start(input int falls);
        drive(1'b0, 1'b1);
        for (int i = 0; i < falls; i++) begin
            drive(1'b0, 1'b0);
            if (i < falls - 1) drive(1'b0, 1'b1);
        end
        drive(1'b1, 1'b0);
    endtask

    // Clock line is always high before it falls; data line only rises or stays low.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            logic d;
            d = b[7 - i];
            if ((i % 2) == 0) begin
                drive(1'b1, d);
                drive(1'b0, d);
                drive(1'b0, 1'b1);
            end else begin
                drive(d, 1'b1);
                drive(d, 1'b0);
                drive(1'b1, 1'b0);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic space, input logic expect_rx);
        if (expect_rx) begin
            if (space) exp_q.push_back(b);
            else model_flags[4] = 1'b1;
        end
        fifo_if.space_avail = space;
        send_bits(b, 8);
        fifo_if.space_avail = 1'b1;
    endtask

    task automatic send_end(input logic expect_rx);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        if (expect_rx) model_flags[1] = 1'b1;
    endtask

    logic [7:0] st;

    initial begin
        fifo_if.space_avail = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_produce", fifo_if.data_produce, 1'b0);
        check("reset_fifo_data", fifo_if.fifo_data, 8'h00);
        rst = 1'b0;
        read_status(st);
        check("reset_status", st, 8'h00);
        write_reg(8'h01);

        send_start(4);
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b1, 1'b1);
        send_end(1'b1);
        read_status(st);
        check("frame_status", st, 8'h02);
        check("frame_model", st, model_flags);
        check("frame_drained", exp_q.size(), 0);
        write_reg(8'h03);
        read_status(st);
        check("done_cleared", st, 8'h00);

        send_start(3);
        read_status(st);
        check("start_err", st, 8'h04);
        write_reg(8'h04);
        read_status(st);
        check("start_err_clear", st, 8'h00);
        write_reg(8'h01);
        drive(1'b1, 1'b1);

        send_start(4);
        send_byte(8'h55, 1'b0, 1'b1);
        send_byte(8'h81, 1'b1, 1'b1);
        send_end(1'b1);
        read_status(st);
        check("overflow_status", st, 8'h12);
        check("overflow_drained", exp_q.size(), 0);
        write_reg(8'h3f);

        send_start(4);
        send_bits(8'hB0, 3);
        read_status(st);
        check("busy_mid_byte", st, 8'h01);
        repeat (120) @(negedge clk);
        read_status(st);
        check("timeout_status", st, 8'h20);
        write_reg(8'h3f);
        drive(1'b1, 1'b1);

        send_start(4);
        send_bits(8'h40, 2);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        read_status(st);
        check("proto_bitcnt2", st, 8'h08);
        write_reg(8'h3f);
        drive(1'b1, 1'b1);

        send_start(4);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        read_status(st);
        check("proto_simul", st, 8'h08);
        write_reg(8'h3f);
        drive(1'b1, 1'b1);

        tx_active = 1'b1;
        send_start(4);
        send_byte(8'hC3, 1'b1, 1'b0);
        send_end(1'b0);
        read_status(st);
        tx_active = 1'b0;
        check("tx_active_quiet", st, 8'h00);

        send_start(4);
        send_bits(8'hFF, 2);
        write_reg(8'h00);
        drive(1'b1, 1'b1);
        read_status(st);
        check("disable_abort", st, 8'h00);
        write_reg(8'h01);

        for (int f = 0; f < 6; f++) begin
            int nb;
            nb = $urandom_range(1, 3);
            send_start(4);
            for (int k = 0; k < nb; k++)
                send_byte(8'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
            send_end(1'b1);
            read_status(st);
            check("random_status", st, model_flags);
            check("random_drained", exp_q.size(), 0);
            write_reg(8'h3f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
